// File: rtl/isqrt_pkg.sv
// Shared widths and state encoding for the sequential integer square root.
`timescale 1ns/1ps
package isqrt_pkg;
  localparam int ISQRT_W = 16;
  localparam int ROOT_W  = ISQRT_W / 2;
  localparam int REM_W   = ISQRT_W / 2 + 1;
  // {r,d} is REM_W+2 bits; the trial difference must span it
  localparam int TRIAL_W = REM_W + 2;
  localparam int CNT_W   = $clog2(ROOT_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } isqrt_state_t;
endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root digit step: trial subtract {q,01} from {r,d}
// via lookahead add of the inverted operand; keep the difference if >= 0.
`timescale 1ns/1ps
module isqrt_step
  import isqrt_pkg::*;
(
  input  logic [REM_W-1:0]  r,
  input  logic [ROOT_W-1:0] q,
  input  logic [1:0]        d,
  output logic [REM_W-1:0]  r_nxt,
  output logic [ROOT_W-1:0] q_nxt
);
  logic [TRIAL_W-1:0] rd, qd, gen, prp, sum;
  logic [TRIAL_W:0]   cy;
  logic               non_neg;

  assign rd  = {r, d};
  assign qd  = {{(TRIAL_W-ROOT_W-2){1'b0}}, q, 2'b01};
  assign gen = rd & ~qd;
  assign prp = rd ^ ~qd;

  // Each carry formed directly from g/p terms and the carry-in of 1
  always_comb begin
    logic acc, pp;
    cy = '0;
    cy[0] = 1'b1;
    for (int i = 0; i < TRIAL_W; i++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc = acc | (pp & gen[j]);
        pp  = pp & prp[j];
      end
      cy[i+1] = acc | pp;
    end
  end

  assign sum     = prp ^ cy[TRIAL_W-1:0];
  assign non_neg = cy[TRIAL_W];
  assign r_nxt   = non_neg ? sum[REM_W-1:0] : rd[REM_W-1:0];
  assign q_nxt   = {q[ROOT_W-2:0], non_neg};
endmodule

// File: rtl/isqrt_seq.sv
// Sequential 16-bit integer square root: one root bit per cycle,
// valid/ready on both sides, result held until consumed.
`timescale 1ns/1ps
module isqrt_seq
  import isqrt_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [ISQRT_W-1:0] X_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [ROOT_W-1:0]  root_o,
  output logic [REM_W-1:0]   rem_o,
  output logic               out_valid_o,
  input  logic               out_ready_i
);
  isqrt_state_t       state;
  logic [ISQRT_W-1:0] x_sh;
  logic [ROOT_W-1:0]  q, q_nxt;
  logic [REM_W-1:0]   r, r_nxt;
  logic [CNT_W-1:0]   k;

  isqrt_step u_step (
    .r     (r),
    .q     (q),
    .d     (x_sh[ISQRT_W-1 -: 2]),
    .r_nxt (r_nxt),
    .q_nxt (q_nxt)
  );

  // Control FSM plus datapath registers; outputs are all registered
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      x_sh        <= '0;
      q           <= '0;
      r           <= '0;
      k           <= '0;
      root_o      <= '0;
      rem_o       <= '0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid_i) begin
          x_sh       <= X_i;
          q          <= '0;
          r          <= '0;
          k          <= CNT_W'(ROOT_W - 1);
          in_ready_o <= 1'b0;
          state      <= CALC;
        end
        CALC: begin
          r    <= r_nxt;
          q    <= q_nxt;
          x_sh <= x_sh << 2;
          if (k == '0) begin
            root_o      <= q_nxt;
            rem_o       <= r_nxt;
            out_valid_o <= 1'b1;
            state       <= DONE;
          end else begin
            k <= k - 1'b1;
          end
        end
        DONE: if (out_ready_i) begin
          out_valid_o <= 1'b0;
          in_ready_o  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_isqrt_seq.sv
// Scoreboard bench for isqrt_seq: directed corners plus a random sweep.
`timescale 1ns/1ps
module tb_isqrt_seq;
  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [15:0] X_i = '0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [7:0]  root_o;
  logic [8:0]  rem_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        dir_rdy = 1'b0;
  logic        rnd_rdy = 1'b0;
  logic        rand_rdy = 1'b0;

  assign out_ready_i = rand_rdy ? rnd_rdy : dir_rdy;

  isqrt_seq dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .X_i         (X_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .root_o      (root_o),
    .rem_o       (rem_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] x;
    logic [7:0]  root;
    logic [8:0]  rem;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference: largest r with r*r <= x, remainder is the leftover
  function automatic exp_t model(input logic [15:0] x);
    exp_t e;
    int   xi, rt;
    xi = int'(x);
    rt = 0;
    while ((rt + 1) * (rt + 1) <= xi) rt++;
    e.x    = x;
    e.root = 8'(rt);
    e.rem  = 9'(xi - rt * rt);
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pop one expectation per output handshake
  always @(negedge clk_i) begin
    if (rst_n_i && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("root x=%0d", mon_e.x), int'(root_o), int'(mon_e.root));
        chk($sformatf("rem x=%0d", mon_e.x), int'(rem_o), int'(mon_e.rem));
      end
    end
  end

  // Random backpressure source for the sweep
  always @(posedge clk_i) begin
    #1;
    rnd_rdy = 1'($urandom_range(0, 1));
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [15:0] x);
    int n = 0;
    while (!in_ready_o && n < 300) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!in_ready_o) begin
      chk("accept_timeout", 0, 1);
    end else begin
      in_valid_i = 1'b1;
      X_i        = x;
      sb.push_back(model(x));
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid_o && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!out_valid_o) chk("valid_timeout", 0, 1);
  endtask

  initial begin
    int          n;
    int          saw_valid;
    logic [7:0]  r0;
    logic [8:0]  m0;
    logic [15:0] xs [5] = '{16'd65535, 16'd65025, 16'd144, 16'd145, 16'd143};
    logic [15:0] x;
    int          rt;

    // Reset state
    #12;
    chk("rst_in_ready", int'(in_ready_o), 1);
    chk("rst_out_valid", int'(out_valid_o), 0);
    chk("rst_root", int'(root_o), 0);
    chk("rst_rem", int'(rem_o), 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // X=0 and accept-to-valid latency
    dir_rdy = 1'b1;
    send(16'd0);
    chk("in_ready_low_after_accept", int'(in_ready_o), 0);
    wait_valid(n);
    chk("latency", n, 8);
    @(posedge clk_i); #1;

    foreach (xs[i]) send(xs[i]);
    wait_valid(n);
    @(posedge clk_i); #1;

    // Backpressure with ignored input pulses
    dir_rdy = 1'b0;
    send(16'd65535);
    wait_valid(n);
    r0 = root_o;
    m0 = rem_o;
    repeat (5) begin
      in_valid_i = 1'b1;
      X_i        = 16'($urandom);
      @(posedge clk_i); #1;
      chk("bp_root_stable", int'(root_o), int'(r0));
      chk("bp_rem_stable", int'(rem_o), int'(m0));
      chk("bp_valid_held", int'(out_valid_o), 1);
      chk("bp_in_ready", int'(in_ready_o), 0);
    end
    in_valid_i = 1'b0;
    dir_rdy    = 1'b1;
    @(posedge clk_i); #1;
    chk("post_hs_valid", int'(out_valid_o), 0);
    chk("post_hs_ready", int'(in_ready_o), 1);
    send(16'd65025);
    chk("accept_at_U+1", int'(in_ready_o), 0);
    wait_valid(n);
    @(posedge clk_i); #1;

    // Reset during CALC
    send(16'd1000);
    repeat (4) @(posedge clk_i);
    #2;
    rst_n_i = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_in_ready", int'(in_ready_o), 1);
    chk("mid_rst_out_valid", int'(out_valid_o), 0);
    chk("mid_rst_root", int'(root_o), 0);
    chk("mid_rst_rem", int'(rem_o), 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    saw_valid = 0;
    repeat (15) begin
      @(posedge clk_i); #1;
      if (out_valid_o) saw_valid = 1;
    end
    chk("no_valid_after_rst", saw_valid, 0);
    send(16'd81);
    wait_valid(n);
    @(posedge clk_i); #1;

    // Random sweep with toggling ready
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (i % 8 == 0) begin
        rt = int'($urandom_range(0, 255));
        x  = 16'(rt * rt - ((i % 16 == 0) ? 1 : 0));
      end else begin
        x = 16'($urandom);
      end
      send(x);
    end
    rand_rdy = 1'b0;
    dir_rdy  = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
